// File: rtl/mem_wb_stage_reg.sv
// mem_wb_stage_reg: MEM->WB pipeline register with stall/flush, WB mux, WB->EX forwarding compare and retire counter
module mem_wb_stage_reg #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  load_data_in,
   input  logic [DATA_W-1:0]  alu_data_in,
   input  logic [RADDR_W-1:0] rd_in,
   input  logic               load_inst_in,
   input  logic               rf_en_in,
   input  logic [RADDR_W-1:0] src_a,
   input  logic [RADDR_W-1:0] src_b,
   input  logic               retire_clear,
   output logic [DATA_W-1:0]  load_data_out,
   output logic [DATA_W-1:0]  alu_data_out,
   output logic [RADDR_W-1:0] rd_out,
   output logic               load_inst_out,
   output logic               rf_en_out,
   output logic               valid_out,
   output logic [DATA_W-1:0]  wb_data,
   output logic               wb_en,
   output logic               fwd_a,
   output logic               fwd_b,
   output logic [CNT_W-1:0]   retire_count
);
   logic retire;
   always_ff @(posedge clk) begin
      if (reset) begin
         load_data_out <= '0;
         alu_data_out  <= '0;
         rd_out        <= '0;
         load_inst_out <= 1'b0;
         rf_en_out     <= 1'b0;
         valid_out     <= 1'b0;
      end else if (flush) begin
         load_inst_out <= 1'b0;
         rf_en_out     <= 1'b0;
         valid_out     <= 1'b0;
      end else if (!stall) begin
         load_data_out <= load_data_in;
         alu_data_out  <= alu_data_in;
         rd_out        <= rd_in;
         load_inst_out <= load_inst_in;
         rf_en_out     <= rf_en_in;
         valid_out     <= in_valid;
      end
   end
   // an instruction retires only when it actually leaves WB (not held, not squashed)
   assign retire = valid_out & ~stall & ~flush;
   always_ff @(posedge clk) begin
      if (reset || retire_clear)
         retire_count <= '0;
      else if (retire && retire_count != {CNT_W{1'b1}})
         retire_count <= retire_count + 1'b1;
   end
   assign wb_data = load_inst_out ? load_data_out : alu_data_out;
   assign wb_en   = rf_en_out & valid_out;
   assign fwd_a   = wb_en & (rd_out == src_a);
   assign fwd_b   = wb_en & (rd_out == src_b);
endmodule
